// File: rtl/crcu_pkg.sv
// Shared constants and types for the CRCU DB unit clock configuration block.
package crcu_pkg;
  localparam int unsigned CTL_OFF    = 32'h00;
  localparam int unsigned STATUS_OFF = 32'h04;
  localparam int unsigned ID_OFF     = 32'h08;

  localparam int unsigned SEL_LSB  = 0;
  localparam int unsigned EN_BIT   = 3;
  localparam int unsigned GATE_BIT = 4;

  typedef enum logic [2:0] {
    F100 = 3'd0,
    F125 = 3'd1,
    F180 = 3'd2,
    F300 = 3'd3,
    F600 = 3'd4
  } freq_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISABLE,
    ST_SWITCH,
    ST_RESTORE
  } cfg_state_e;

  function automatic logic legal_sel(input logic [2:0] sel);
    return sel <= F600;
  endfunction
endpackage

// File: rtl/crcu_apb_slave_if.sv
// APB3 responder handshake: wait-state counting, stall, PREADY/PSLVERR and strobes.
module crcu_apb_slave_if #(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic        stall,
  input  logic        err,
  input  logic [31:0] rdata,
  output logic        pready,
  output logic        pslverr,
  output logic [31:0] prdata,
  output logic        wr_en
);
  logic [3:0] ws_cnt;
  logic       access, ws_done, rd_stb;

  assign access  = psel & penable;
  assign ws_done = (ws_cnt == 4'(WAIT_STATES));
  assign pready  = access & ws_done & ~stall;
  assign pslverr = pready & err;
  assign wr_en   = pready & pwrite & ~err;
  assign rd_stb  = pready & ~pwrite & ~err;
  assign prdata  = rd_stb ? rdata : '0;

  // Counter saturates at WAIT_STATES so a stall simply extends the last wait cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ws_cnt <= '0;
    else if (!access || pready) ws_cnt <= '0;
    else if (!ws_done)          ws_cnt <= ws_cnt + 4'd1;
  end
endmodule

// File: rtl/crcu_db_unit_clk_cfg_apb.sv
// DB unit clock control register with APB access and safe disable/switch/restore sequencing.
module crcu_db_unit_clk_cfg_apb
  import crcu_pkg::*;
#(
  parameter int          ADDR_W        = 8,
  parameter int          WAIT_STATES   = 0,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [31:0] RESET_CTL     = 32'h0000_0008,
  parameter logic [31:0] ID_VALUE      = 32'h4352_4355
) (
  input  logic              CRCU_CLK,
  input  logic              CRCU_RST_N,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [31:0]       db_unit_clock_ctl_reg,
  output logic              clk_cfg_busy
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SETTLE_CYCLES);
  localparam logic [ADDR_W-3:0] CTL_W = (ADDR_W-2)'(CTL_OFF >> 2);
  localparam logic [ADDR_W-3:0] STS_W = (ADDR_W-2)'(STATUS_OFF >> 2);
  localparam logic [ADDR_W-3:0] ID_W  = (ADDR_W-2)'(ID_OFF >> 2);

  cfg_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       shadow, ctl_q;
  logic             busy;
  logic [ADDR_W-3:0] word;
  logic             hit_ctl, hit_sts, hit_id, err, stall, wr_en;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign word        = PADDR[ADDR_W-1:2];
  assign unused_bits = &{1'b0, PADDR[1:0], PWDATA[31:5]};
  assign hit_ctl     = (word == CTL_W);
  assign hit_sts     = (word == STS_W);
  assign hit_id      = (word == ID_W);

  assign err = ~(hit_ctl | hit_sts | hit_id)
             | (PWRITE & (hit_sts | hit_id))
             | (PWRITE & hit_ctl & ~legal_sel(PWDATA[2:0]));
  // CTL writes wait out a running sequence rather than erroring.
  assign stall = PSEL & PENABLE & PWRITE & hit_ctl & busy;

  always_comb begin
    rdata = '0;
    if (hit_ctl)      rdata = {27'b0, shadow};
    else if (hit_sts) rdata = {26'b0, ctl_q[GATE_BIT], ctl_q[EN_BIT], ctl_q[2:0], busy};
    else if (hit_id)  rdata = ID_VALUE;
  end

  crcu_apb_slave_if #(.WAIT_STATES(WAIT_STATES)) u_apb (
    .clk     (CRCU_CLK),
    .rst_n   (CRCU_RST_N),
    .psel    (PSEL),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .stall   (stall),
    .err     (err),
    .rdata   (rdata),
    .pready  (PREADY),
    .pslverr (PSLVERR),
    .prdata  (PRDATA),
    .wr_en   (wr_en)
  );

  always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
    if (!CRCU_RST_N) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      shadow <= RESET_CTL[4:0];
      ctl_q  <= RESET_CTL[4:0];
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_en && hit_ctl) begin
            shadow <= PWDATA[4:0];
            if (PWDATA[2:0] != ctl_q[2:0]) begin
              state           <= ST_DISABLE;
              busy            <= 1'b1;
              cnt             <= '0;
              ctl_q[EN_BIT]   <= 1'b0;
              ctl_q[GATE_BIT] <= 1'b1;
            end else begin
              ctl_q[4:3] <= PWDATA[4:3];
            end
          end
        end
        ST_DISABLE: begin
          if (cnt == CNT_LAST) begin
            state      <= ST_SWITCH;
            cnt        <= '0;
            ctl_q[2:0] <= shadow[2:0];
          end else begin
            cnt <= (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
          end
        end
        ST_SWITCH: begin
          if (cnt == CNT_LAST) begin
            state      <= ST_RESTORE;
            cnt        <= '0;
            ctl_q[4:3] <= shadow[4:3];
          end else begin
            cnt <= (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign db_unit_clock_ctl_reg = {27'b0, ctl_q};
  assign clk_cfg_busy          = busy;
endmodule

// File: tb/tb_crcu_db_unit_clk_cfg_apb.sv
// Directed bench: one instance with no wait states, one with three.
module tb_crcu_db_unit_clk_cfg_apb;
  logic        CRCU_CLK = 1'b0;
  logic        CRCU_RST_N;
  logic        psel0, psel1, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] prdata0, prdata1, ctl0, ctl1;
  logic        pready0, pready1, pslverr0, pslverr1, busy0, busy1;
  int          checks = 0, errors = 0;
  logic [31:0] rd;
  logic        er;
  int          wt;

  always #5 CRCU_CLK = ~CRCU_CLK;

  crcu_db_unit_clk_cfg_apb #(.WAIT_STATES(0)) dut0 (
    .CRCU_CLK(CRCU_CLK), .CRCU_RST_N(CRCU_RST_N), .PSEL(psel0), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .db_unit_clock_ctl_reg(ctl0), .clk_cfg_busy(busy0));

  crcu_db_unit_clk_cfg_apb #(.WAIT_STATES(3)) dut1 (
    .CRCU_CLK(CRCU_CLK), .CRCU_RST_N(CRCU_RST_N), .PSEL(psel1), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .db_unit_clock_ctl_reg(ctl1), .clk_cfg_busy(busy1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb(input bit inst, input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int waits);
    bit done = 0;
    @(posedge CRCU_CLK); #1;
    if (inst) psel1 = 1'b1; else psel0 = 1'b1;
    PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge CRCU_CLK);
    check("setup_pready", {31'b0, inst ? pready1 : pready0}, 32'd0);
    @(posedge CRCU_CLK); #1 PENABLE = 1'b1;
    waits = 0; rdata = '0; err = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CRCU_CLK);
      if (inst ? pready1 : pready0) begin
        done  = 1;
        rdata = inst ? prdata1 : prdata0;
        err   = inst ? pslverr1 : pslverr0;
      end else waits++;
    end
    if (!done) check("apb_timeout", 32'd0, 32'd1);
    @(posedge CRCU_CLK); #1;
    psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr0(input string tag, input logic [7:0] a, input logic [31:0] d, input logic exp_err);
    apb(1'b0, 1'b1, a, d, rd, er, wt);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  task automatic rd0(input string tag, input logic [7:0] a, input logic [31:0] exp, input logic exp_err);
    apb(1'b0, 1'b0, a, 32'h0, rd, er, wt);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    check({tag, "_data"}, rd, exp);
  endtask

  initial begin
    CRCU_RST_N = 1'b0; psel0 = 0; psel1 = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge CRCU_CLK);
    #1 CRCU_RST_N = 1'b1;
    @(negedge CRCU_CLK);
    check("rst_ctl", ctl0, 32'h08);
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_prdata", prdata0, 32'd0);
    check("rst_pready", {31'b0, pready0}, 32'd0);
    check("rst_pslverr", {31'b0, pslverr0}, 32'd0);
    rd0("rst_rd_ctl", 8'h00, 32'h08, 1'b0);
    rd0("rst_rd_sts", 8'h04, 32'h10, 1'b0);
    rd0("rd_id", 8'h08, 32'h4352_4355, 1'b0);

    // same select: enable/gate bits apply directly, no sequence
    wr0("wr_00", 8'h00, 32'h00, 1'b0);
    check("wr_00_out", ctl0, 32'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge CRCU_CLK);
      check("wr_00_busy", {31'b0, busy0}, 32'd0);
    end
    rd0("rd_00", 8'h00, 32'h00, 1'b0);
    wr0("wr_08", 8'h00, 32'h08, 1'b0);
    check("wr_08_out", ctl0, 32'h08);

    wr0("wr_sel6", 8'h00, 32'h06, 1'b1);
    wr0("wr_sel7", 8'h00, 32'h0F, 1'b1);
    check("bad_sel_out", ctl0, 32'h08);
    rd0("bad_sel_rb", 8'h00, 32'h08, 1'b0);
    wr0("wr_sts", 8'h04, 32'h3F, 1'b1);
    wr0("wr_id", 8'h08, 32'h00, 1'b1);
    rd0("rd_0c", 8'h0C, 32'h00, 1'b1);
    rd0("rd_alias", 8'h01, 32'h08, 1'b0);
    check("ro_out", ctl0, 32'h08);

    // 000 -> 011 full sequence
    wr0("wr_0b", 8'h00, 32'h0B, 1'b0);
    for (int i = 0; i < 33; i++) begin
      @(negedge CRCU_CLK);
      check($sformatf("seq_out_%0d", i), ctl0, (i < 16) ? 32'h10 : (i < 32) ? 32'h13 : 32'h0B);
      check($sformatf("seq_busy_%0d", i), {31'b0, busy0}, 32'd1);
    end
    @(negedge CRCU_CLK);
    check("seq_done_busy", {31'b0, busy0}, 32'd0);
    check("seq_done_out", ctl0, 32'h0B);
    rd0("rd_0b", 8'h00, 32'h0B, 1'b0);
    rd0("rd_sts_0b", 8'h04, 32'h16, 1'b0);

    // status read mid-sequence, then a stalled CTL write
    wr0("wr_0a", 8'h00, 32'h0A, 1'b0);
    rd0("rd_sts_mid", 8'h04, 32'h27, 1'b0);
    rd0("rd_ctl_mid", 8'h00, 32'h0A, 1'b0);
    wr0("wr_0c", 8'h00, 32'h0C, 1'b0);
    check("stall_waits", {31'b0, wt > 10}, 32'd1);
    @(negedge CRCU_CLK);
    check("2nd_busy", {31'b0, busy0}, 32'd1);
    check("2nd_disable", ctl0, 32'h12);
    for (int c = 0; c < 100 && busy0; c++) @(negedge CRCU_CLK);
    check("2nd_done_busy", {31'b0, busy0}, 32'd0);
    check("2nd_done_out", ctl0, 32'h0C);

    // reset in the middle of a sequence
    wr0("wr_rst_seq", 8'h00, 32'h0B, 1'b0);
    repeat (5) @(negedge CRCU_CLK);
    check("pre_rst_busy", {31'b0, busy0}, 32'd1);
    CRCU_RST_N = 1'b0;
    #1;
    check("mid_rst_out", ctl0, 32'h08);
    check("mid_rst_busy", {31'b0, busy0}, 32'd0);
    @(posedge CRCU_CLK); #1 CRCU_RST_N = 1'b1;
    rd0("post_rst_ctl", 8'h00, 32'h08, 1'b0);
    rd0("post_rst_sts", 8'h04, 32'h10, 1'b0);
    repeat (20) @(negedge CRCU_CLK);
    check("post_rst_out", ctl0, 32'h08);
    check("post_rst_busy", {31'b0, busy0}, 32'd0);

    // three wait states
    apb(1'b1, 1'b0, 8'h08, 32'h0, rd, er, wt);
    check("ws3_id_data", rd, 32'h4352_4355);
    check("ws3_id_waits", wt, 32'd3);
    check("ws3_id_err", {31'b0, er}, 32'd0);
    apb(1'b1, 1'b1, 8'h00, 32'h00, rd, er, wt);
    check("ws3_wr_waits", wt, 32'd3);
    check("ws3_wr_err", {31'b0, er}, 32'd0);
    check("ws3_wr_out", ctl1, 32'h00);
    apb(1'b1, 1'b0, 8'h10, 32'h0, rd, er, wt);
    check("ws3_bad_waits", wt, 32'd3);
    check("ws3_bad_err", {31'b0, er}, 32'd1);
    check("ws3_bad_data", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
